// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_stage_reg_pkg
//  Purpose : Shared types and constants for the inter-stage pipeline register.
//            Holds the per-cycle action encoding produced by pipe_stage_ctl,
//            the default stall-bus and payload widths, and a small helper that
//            tells whether an action empties the boundary.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pipe_stage_reg_pkg;

  // Width of the per-stage stall vector driven by the pipeline controller.
  localparam int STALL_BUS_W = 6;

  // Default payload width for the 32-bit MIPS core.
  localparam int DATA_W_DEF = 32;

  // Default bubble payload; an all-zero word decodes as sll $0,$0,0 (a NOP).
  localparam logic [DATA_W_DEF-1:0] NOP_PAYLOAD = '0;

  // One action is selected per cycle, listed here from highest priority down.
  typedef enum logic [2:0] {
    ACT_RESET  = 3'd0,
    ACT_FLUSH  = 3'd1,
    ACT_BUBBLE = 3'd2,
    ACT_HOLD   = 3'd3,
    ACT_LOAD   = 3'd4
  } action_e;

  // RESET, FLUSH and BUBBLE all leave an empty NOP entry in the boundary.
  function automatic logic is_empty_action(input action_e act);
    return (act == ACT_RESET) || (act == ACT_FLUSH) || (act == ACT_BUBBLE);
  endfunction

endpackage : pipe_stage_reg_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_ctl.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_stage_ctl
//  Purpose : Combinational priority decoder choosing the action a pipeline
//            boundary register takes this cycle.
//  Ports   : rst       in  synchronous reset request
//            flush_i   in  exception/eret flush
//            stall_i   in  per-stage stall vector (bit set = stage held)
//            action_o  out selected action (RESET > FLUSH > BUBBLE > HOLD > LOAD)
//  Rev     : 1.0  initial release
// ============================================================================
module pipe_stage_ctl
  import pipe_stage_reg_pkg::*;
#(
  parameter int STALL_W = STALL_BUS_W,
  parameter int STAGE   = 2
) (
  input  logic               rst,
  input  logic               flush_i,
  input  logic [STALL_W-1:0] stall_i,
  output action_e            action_o
);

  logic stall_up;
  logic stall_dn;

  assign stall_up = stall_i[STAGE];
  assign stall_dn = stall_i[STAGE+1];

  // Only the two stages adjacent to this boundary matter; the rest of the
  // vector is folded into a sink so it is visibly intentionally ignored.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall_i;

  always_comb begin
    action_o = ACT_LOAD;
    if (rst) begin
      action_o = ACT_RESET;
    end else if (flush_i) begin
      action_o = ACT_FLUSH;
    end else if (stall_up && !stall_dn) begin
      // Upstream held but downstream free: downstream must see an empty slot,
      // otherwise it would re-execute the instruction already passed on.
      action_o = ACT_BUBBLE;
    end else if (stall_up) begin
      action_o = ACT_HOLD;
    end
  end

endmodule : pipe_stage_ctl
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module  : pipe_stage_reg
//  Purpose : Parametrised inter-stage pipeline register (if_id, id_ex, ex_mem,
//            mem_wb) with valid bit, flush, configurable bubble payload and
//            saturating stall/bubble event counters for the perf monitor.
//  Ports   : clk           in  rising-edge clock
//            rst           in  synchronous active-high reset
//            stall_i       in  per-stage stall vector
//            flush_i       in  exception/eret flush of this boundary
//            up_valid_i    in  upstream holds a real instruction
//            up_data_i     in  upstream payload
//            up_dslot_i    in  upstream instruction is in a delay slot
//            next_dslot_i  in  next fetched instruction is in a delay slot
//            cnt_clr_i     in  synchronous clear of both counters
//            dn_valid_o    out registered valid
//            dn_data_o     out registered payload
//            dn_dslot_o    out registered delay-slot flag
//            dslot_loop_o  out registered next_dslot_i, looped back to ID
//            stall_cnt_o   out cycles spent in HOLD (saturating)
//            bubble_cnt_o  out bubbles inserted (saturating)
//  Rev     : 1.0  initial release
// ============================================================================
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                STAGE     = 2,
  parameter int                STALL_W   = STALL_BUS_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               up_valid_i,
  input  logic [DATA_W-1:0]  up_data_i,
  input  logic               up_dslot_i,
  input  logic               next_dslot_i,
  input  logic               cnt_clr_i,
  output logic               dn_valid_o,
  output logic [DATA_W-1:0]  dn_data_o,
  output logic               dn_dslot_o,
  output logic               dslot_loop_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  // Elaboration-time guard: the downstream stall bit must exist.
  generate
    if (STAGE + 1 >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
    end
  endgenerate

  action_e action;

  pipe_stage_ctl #(
    .STALL_W (STALL_W),
    .STAGE   (STAGE)
  ) u_ctl (
    .rst      (rst),
    .flush_i  (flush_i),
    .stall_i  (stall_i),
    .action_o (action)
  );

  logic              valid_q,      valid_d;
  logic [DATA_W-1:0] data_q,       data_d;
  logic              dslot_q,      dslot_d;
  logic              loop_q,       loop_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  // Payload / flag registers.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    dslot_d = dslot_q;
    loop_d  = loop_q;
    if (is_empty_action(action)) begin
      valid_d = 1'b0;
      data_d  = NOP_VALUE;
      dslot_d = 1'b0;
      loop_d  = 1'b0;
    end else if (action == ACT_LOAD) begin
      // Payload is captured even for invalid entries; consumers gate on valid.
      valid_d = up_valid_i;
      data_d  = up_data_i;
      dslot_d = up_dslot_i;
      loop_d  = next_dslot_i;
    end
  end

  // Event counters: reset and clear both win over an increment, and the count
  // sticks at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (action == ACT_RESET || cnt_clr_i) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (action == ACT_HOLD && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (action == ACT_BUBBLE && bubble_cnt_q != {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      data_q       <= NOP_VALUE;
      dslot_q      <= 1'b0;
      loop_q       <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      dslot_q      <= dslot_d;
      loop_q       <= loop_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign dn_valid_o   = valid_q;
  assign dn_data_o    = data_q;
  assign dn_dslot_o   = dslot_q;
  assign dslot_loop_o = loop_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pipe_stage_reg
//  Purpose : Self-checking bench for pipe_stage_reg. Two instances share the
//            stimulus: a 16-bit-counter instance and a 2-bit-counter instance
//            that exercises counter saturation.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int STAGE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        up_valid_i;
  logic [31:0] up_data_i;
  logic        up_dslot_i;
  logic        next_dslot_i;
  logic        cnt_clr_i;

  logic        a_valid, a_dslot, a_loop;
  logic [31:0] a_data;
  logic [15:0] a_scnt, a_bcnt;
  logic        b_valid, b_dslot, b_loop;
  logic [31:0] b_data;
  logic [1:0]  b_scnt, b_bcnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .STAGE(STAGE), .STALL_W(6), .NOP_VALUE(32'h0), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .up_valid_i(up_valid_i), .up_data_i(up_data_i), .up_dslot_i(up_dslot_i),
    .next_dslot_i(next_dslot_i), .cnt_clr_i(cnt_clr_i),
    .dn_valid_o(a_valid), .dn_data_o(a_data), .dn_dslot_o(a_dslot),
    .dslot_loop_o(a_loop), .stall_cnt_o(a_scnt), .bubble_cnt_o(a_bcnt)
  );

  pipe_stage_reg #(.DATA_W(32), .STAGE(STAGE), .STALL_W(6), .NOP_VALUE(32'h0), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .up_valid_i(up_valid_i), .up_data_i(up_data_i), .up_dslot_i(up_dslot_i),
    .next_dslot_i(next_dslot_i), .cnt_clr_i(cnt_clr_i),
    .dn_valid_o(b_valid), .dn_data_o(b_data), .dn_dslot_o(b_dslot),
    .dslot_loop_o(b_loop), .stall_cnt_o(b_scnt), .bubble_cnt_o(b_bcnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_known = 0;
  bit          m_valid, m_dslot, m_loop;
  logic [31:0] m_data;
  int          m_scnt16, m_bcnt16, m_scnt2, m_bcnt2;

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  always @(posedge clk) begin
    bit up_st, dn_st;
    up_st = stall_i[STAGE];
    dn_st = stall_i[STAGE+1];
    if (rst) begin
      m_known = 1;
      {m_valid, m_dslot, m_loop} = '0;
      m_data = 32'h0;
      m_scnt16 = 0; m_bcnt16 = 0; m_scnt2 = 0; m_bcnt2 = 0;
    end else begin
      if (flush_i || (up_st && !dn_st)) begin
        {m_valid, m_dslot, m_loop} = '0;
        m_data = 32'h0;
        if (!flush_i) begin
          m_bcnt16 = sat_inc(m_bcnt16, 65535);
          m_bcnt2  = sat_inc(m_bcnt2, 3);
        end
      end else if (up_st) begin
        m_scnt16 = sat_inc(m_scnt16, 65535);
        m_scnt2  = sat_inc(m_scnt2, 3);
      end else begin
        m_valid = up_valid_i;
        m_data  = up_data_i;
        m_dslot = up_dslot_i;
        m_loop  = next_dslot_i;
      end
      if (cnt_clr_i) begin
        m_scnt16 = 0; m_bcnt16 = 0; m_scnt2 = 0; m_bcnt2 = 0;
      end
    end
  end

  // Per-cycle comparison, one time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (m_known) begin
      check("model_valid",  64'(a_valid), 64'(m_valid));
      check("model_data",   64'(a_data),  64'(m_data));
      check("model_dslot",  64'(a_dslot), 64'(m_dslot));
      check("model_loop",   64'(a_loop),  64'(m_loop));
      check("model_scnt",   64'(a_scnt),  64'(m_scnt16));
      check("model_bcnt",   64'(a_bcnt),  64'(m_bcnt16));
      check("model_valid2", 64'(b_valid), 64'(m_valid));
      check("model_data2",  64'(b_data),  64'(m_data));
      check("model_scnt2",  64'(b_scnt),  64'(m_scnt2));
      check("model_bcnt2",  64'(b_bcnt),  64'(m_bcnt2));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall_i = 6'b0; flush_i = 1'b0; up_valid_i = 1'b1;
    up_data_i = 32'hDEADBEEF; up_dslot_i = 1'b0; next_dslot_i = 1'b0; cnt_clr_i = 1'b0;

    // Reset holds outputs empty even with a valid upstream.
    cycles(2);
    check("rst_valid", 64'(a_valid), 64'h0);
    check("rst_data",  64'(a_data),  64'h0);
    check("rst_scnt",  64'(a_scnt),  64'h0);
    check("rst_bcnt",  64'(a_bcnt),  64'h0);

    // Plain load, one-cycle latency.
    rst = 1'b0; up_data_i = 32'h1234_5678; up_dslot_i = 1'b1; next_dslot_i = 1'b1;
    cycles(1);
    check("load_data",  64'(a_data),  64'h1234_5678);
    check("load_valid", 64'(a_valid), 64'h1);
    check("load_dslot", 64'(a_dslot), 64'h1);
    check("load_loop",  64'(a_loop),  64'h1);

    // Three bubbles.
    stall_i = 6'b000100;
    cycles(3);
    check("bub_valid", 64'(a_valid), 64'h0);
    check("bub_data",  64'(a_data),  64'h0);
    check("bub_loop",  64'(a_loop),  64'h0);
    check("bub_cnt",   64'(a_bcnt),  64'd3);

    // Load A5A5A5A5 then hold four cycles.
    stall_i = 6'b0; up_data_i = 32'hA5A5_A5A5; up_dslot_i = 1'b0; next_dslot_i = 1'b0;
    cycles(1);
    stall_i = 6'b001100; up_data_i = 32'h0BAD_F00D; up_valid_i = 1'b0;
    cycles(4);
    check("hold_data",  64'(a_data),  64'hA5A5_A5A5);
    check("hold_valid", 64'(a_valid), 64'h1);
    check("hold_scnt",  64'(a_scnt),  64'd4);
    check("hold_scnt2", 64'(b_scnt),  64'd3);

    // Flush beats stall; counters unchanged.
    flush_i = 1'b1;
    cycles(1);
    flush_i = 1'b0;
    check("flush_valid", 64'(a_valid), 64'h0);
    check("flush_data",  64'(a_data),  64'h0);
    check("flush_scnt",  64'(a_scnt),  64'd4);
    check("flush_bcnt",  64'(a_bcnt),  64'd3);

    // Five more holds: wide counter 9, narrow counter saturated at 3.
    cycles(5);
    check("sat_scnt",  64'(a_scnt), 64'd9);
    check("sat_scnt2", 64'(b_scnt), 64'd3);
    check("sat_bcnt2", 64'(b_bcnt), 64'd3);

    // Clear during a hold beats the increment.
    cnt_clr_i = 1'b1;
    cycles(1);
    cnt_clr_i = 1'b0;
    check("clr_scnt",  64'(a_scnt), 64'd0);
    check("clr_scnt2", 64'(b_scnt), 64'd0);
    check("clr_bcnt",  64'(a_bcnt), 64'd0);

    // Stall bits outside STAGE/STAGE+1 are ignored: this is a LOAD.
    stall_i = 6'b110011; up_valid_i = 1'b1; up_data_i = 32'hCAFE_0001;
    cycles(1);
    check("ign_data", 64'(a_data), 64'hCAFE_0001);
    check("ign_scnt", 64'(a_scnt), 64'd0);

    // Downstream-only stall is also a LOAD at this boundary.
    stall_i = 6'b001000; up_data_i = 32'hCAFE_0002; up_dslot_i = 1'b1;
    cycles(1);
    check("dnst_data",  64'(a_data),  64'hCAFE_0002);
    check("dnst_dslot", 64'(a_dslot), 64'h1);

    // Reset during a stall, then stall continues as HOLD.
    stall_i = 6'b001100; rst = 1'b1;
    cycles(1);
    check("rstst_valid", 64'(a_valid), 64'h0);
    rst = 1'b0;
    cycles(2);
    check("rstst_scnt",  64'(a_scnt),  64'd2);
    check("rstst_data",  64'(a_data),  64'h0);

    // Invalid payload is still captured on load.
    stall_i = 6'b0; up_valid_i = 1'b0; up_data_i = 32'h7777_8888;
    cycles(1);
    check("inv_data",  64'(a_data),  64'h7777_8888);
    check("inv_valid", 64'(a_valid), 64'h0);

    cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_stage_reg
`default_nettype wire
